// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Shared types and constants for the BNN accelerator datapath blocks.
//   port_input_logic : identifies one bank of the ping-pong feature-map BRAM
//   ofmap_state_t    : state encoding of the output-feature-map writer FSM
//   MAX_OUT_SIZE     : largest output width/height the writer accepts
// ---------------------------------------------------------------------------
package bnn_pkg;

  typedef enum logic {
    BRAM_A = 1'b0,
    BRAM_B = 1'b1
  } port_input_logic;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ofmap_state_t;

  localparam int MAX_OUT_SIZE = 255;

endpackage

// File: rtl/ofmap_addr_gen.sv
// ---------------------------------------------------------------------------
// ofmap_addr_gen
// Output-size arithmetic and write-address counter for ofmap_writer.
//   clk, rst      : clock and asynchronous active-low reset
//   clear         : layer start accepted; address counter returns to 0
//   calc          : FSM is in CALC; out_size and total are registered
//   step          : one word accepted; address counter advances
//   image_size,
//   kernel_size,
//   padding,
//   stride        : latched layer configuration
//   out_size      : registered output width/height
//   cfg_err       : combinational configuration error, meaningful in CALC
//   addr          : current write address
//   last          : addr holds the final word of the layer
// ---------------------------------------------------------------------------
module ofmap_addr_gen
  import bnn_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              calc,
  input  logic              step,
  input  logic [15:0]       image_size,
  input  logic [3:0]        kernel_size,
  input  logic              padding,
  input  logic [1:0]        stride,
  output logic [15:0]       out_size,
  output logic              cfg_err,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [16:0] eff;
  logic [16:0] diff;
  logic [16:0] quot;
  logic [16:0] out_calc;
  logic [15:0] total;

  // 17-bit arithmetic so that image_size plus padding cannot overflow.
  // Stride 0 behaves as stride 1, stride 2 is a halving shift and stride 3
  // is flagged as an error. diff is garbage when eff < kernel, but that case
  // is already an error so the result is never used.
  always_comb begin
    eff      = {1'b0, image_size} + (padding ? 17'd2 : 17'd0);
    diff     = eff - {13'd0, kernel_size};
    quot     = (stride == 2'd2) ? (diff >> 1) : diff;
    out_calc = quot + 17'd1;
    cfg_err  = (stride == 2'd3) ||
               (eff < {13'd0, kernel_size}) ||
               (kernel_size == 4'd0) ||
               (out_calc > 17'(MAX_OUT_SIZE));
  end

  // out_size and the word total are captured once in CALC and held for the
  // rest of the layer. out_size never exceeds 255 on the good path, so the
  // square always fits in 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_size <= 16'd0;
      total    <= 16'd0;
    end else if (calc) begin
      if (cfg_err) begin
        out_size <= 16'd0;
        total    <= 16'd0;
      end else begin
        out_size <= out_calc[15:0];
        total    <= {8'd0, out_calc[7:0]} * {8'd0, out_calc[7:0]};
      end
    end
  end

  // Row-major write address: restarts at every accepted start and advances
  // by one on every accepted word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
    end
  end

  // Terminal count: the word being accepted at this address is the last one.
  assign last = (addr == ADDR_W'(total - 16'd1));

endmodule

// File: rtl/ofmap_writer.sv
// ---------------------------------------------------------------------------
// ofmap_writer
// Output-feature-map write-back controller. Accepts binarized PE results over
// a valid/ready handshake and writes them row-major into the ping-pong BRAM
// bank opposite the one currently being read.
//   clk, rst      : clock and asynchronous active-low reset
//   start         : single-cycle layer start, honoured only in IDLE
//   image_size,
//   kernel_size,
//   padding,
//   stride        : layer configuration, latched on start
//   port_input    : bank being read; writes go to the other bank
//   pe_valid,
//   pe_data,
//   pe_ready      : PE result handshake
//   wr_en_a,
//   wr_en_b,
//   wr_addr,
//   wr_data       : registered BRAM write port (one cycle after handshake)
//   out_size      : computed output width/height
//   busy          : high outside IDLE
//   done          : one-cycle pulse at layer completion
//   err           : sticky configuration error, cleared by the next start
//   stall_cycles  : only with OFMAP_STALL_CNT_EN defined; WRITE cycles in
//                   which pe_valid was low
// Optional feature macro: OFMAP_STALL_CNT_EN
// ---------------------------------------------------------------------------
module ofmap_writer
  import bnn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       image_size,
  input  logic [3:0]        kernel_size,
  input  logic              padding,
  input  logic [1:0]        stride,
  input  port_input_logic   port_input,
  input  logic              pe_valid,
  input  logic [DATA_W-1:0] pe_data,
  output logic              pe_ready,
  output logic              wr_en_a,
  output logic              wr_en_b,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [15:0]       out_size,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef OFMAP_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  ofmap_state_t    state;
  logic [15:0]     image_size_q;
  logic [3:0]      kernel_size_q;
  logic            padding_q;
  logic [1:0]      stride_q;
  port_input_logic target_bank;

  logic              hs;
  logic              start_accept;
  logic              cfg_err;
  logic              last_word;
  logic [ADDR_W-1:0] addr;

  assign hs           = pe_valid & pe_ready;
  assign start_accept = (state == IDLE) & start;

  ofmap_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_accept),
    .calc        (state == CALC),
    .step        (hs),
    .image_size  (image_size_q),
    .kernel_size (kernel_size_q),
    .padding     (padding_q),
    .stride      (stride_q),
    .out_size    (out_size),
    .cfg_err     (cfg_err),
    .addr        (addr),
    .last        (last_word)
  );

  // Main FSM with registered outputs. The write port is a one-cycle
  // registered copy of each handshake. On the good path DONE is the cycle
  // carrying the final strobe and done pulses the cycle after; on the error
  // path done is raised on leaving CALC so it lands two cycles after start.
  // err distinguishes the two cases while in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      image_size_q  <= 16'd0;
      kernel_size_q <= 4'd0;
      padding_q     <= 1'b0;
      stride_q      <= 2'd0;
      target_bank   <= BRAM_A;
      pe_ready      <= 1'b0;
      wr_en_a       <= 1'b0;
      wr_en_b       <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      wr_en_a <= 1'b0;
      wr_en_b <= 1'b0;
      done    <= 1'b0;

      if (hs) begin
        wr_en_a <= (target_bank == BRAM_A);
        wr_en_b <= (target_bank == BRAM_B);
        wr_addr <= addr;
        wr_data <= pe_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            image_size_q  <= image_size;
            kernel_size_q <= kernel_size;
            padding_q     <= padding;
            stride_q      <= stride;
            target_bank   <= (port_input == BRAM_A) ? BRAM_B : BRAM_A;
            err           <= 1'b0;
            busy          <= 1'b1;
            state         <= CALC;
          end
        end
        CALC: begin
          if (cfg_err) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pe_ready <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (hs && last_word) begin
            pe_ready <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= ~err;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          pe_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef OFMAP_STALL_CNT_EN
  // Stall counter: counts WRITE cycles without a valid PE word. Cleared on
  // an accepted start and left untouched after the layer completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'd0;
    end else if (start_accept) begin
      stall_cycles <= 32'd0;
    end else if ((state == WRITE) && !pe_valid) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_ofmap_writer.sv
// ---------------------------------------------------------------------------
// tb_ofmap_writer
// Self-checking bench for ofmap_writer: a table of layer configurations with
// expected output size, word count and error flag, plus hand-written
// sequences for throttled input, mid-layer reset and start-while-busy.
// Expected writes are queued at each handshake and popped on each strobe.
// ---------------------------------------------------------------------------
module tb_ofmap_writer;
  import bnn_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       image_size;
  logic [3:0]        kernel_size;
  logic              padding;
  logic [1:0]        stride;
  port_input_logic   port_input;
  logic              pe_valid;
  logic [DATA_W-1:0] pe_data;
  logic              pe_ready;
  logic              wr_en_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [15:0]       out_size;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  ofmap_writer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .image_size  (image_size),
    .kernel_size (kernel_size),
    .padding     (padding),
    .stride      (stride),
    .port_input  (port_input),
    .pe_valid    (pe_valid),
    .pe_data     (pe_data),
    .pe_ready    (pe_ready),
    .wr_en_a     (wr_en_a),
    .wr_en_b     (wr_en_b),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .out_size    (out_size),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  typedef struct {
    logic [15:0]     image;
    logic [3:0]      kernel;
    logic            pad;
    logic [1:0]      strd;
    port_input_logic port;
    logic [15:0]     expOut;
    int              expTotal;
    logic            expErr;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        bankB;
  } wr_t;

  localparam int NUM_VEC = 11;
  vec_t vec [NUM_VEC];
  wr_t  sb [$];

  int          assertCount = 0;
  int          failCount   = 0;
  int          cyc         = 0;
  int          writesSeen  = 0;
  int          doneCount   = 0;
  int          lastWrCyc   = -100;
  int          doneCyc     = -100;
  logic [15:0] expAddr     = 16'd0;
  logic        expBankB    = 1'b0;
  bit          aborted;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Called once per cycle at the falling edge: pop and compare write strobes
  // and note when done pulses.
  task automatic monitorCycle();
    wr_t e;
    cyc++;
    if (wr_en_a || wr_en_b) begin
      writesSeen++;
      lastWrCyc = cyc;
      checkOutput("strobe_exclusive", 32'(wr_en_a & wr_en_b), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
        checkOutput("wr_data", wr_data, e.data);
        checkOutput("wr_bank_b", 32'(wr_en_b), 32'(e.bankB));
      end
    end
    if (done) begin
      doneCount++;
      doneCyc = cyc;
    end
  endtask

  // Drive one cycle of PE input; a handshake is predicted from the ready
  // level visible now, which is stable until the next rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d);
    pe_valid = v;
    pe_data  = d;
    if (v && pe_ready && rst) begin
      sb.push_back('{addr: expAddr, data: d, bankB: expBankB});
      expAddr = expAddr + 16'd1;
    end
    @(negedge clk);
    monitorCycle();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pe_ready"}, 32'(pe_ready), 32'd0);
    checkOutput({tag, "_wr_en_a"},  32'(wr_en_a),  32'd0);
    checkOutput({tag, "_wr_en_b"},  32'(wr_en_b),  32'd0);
    checkOutput({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
    checkOutput({tag, "_wr_data"},  wr_data,       32'd0);
    checkOutput({tag, "_out_size"}, 32'(out_size), 32'd0);
    checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    checkOutput({tag, "_done"},     32'(done),     32'd0);
    checkOutput({tag, "_err"},      32'(err),      32'd0);
  endtask

  // One complete layer. mode 0: pe_valid held high, mode 1: every other
  // cycle. inject: pulse start with a different configuration mid-layer.
  // abortAt > 0: assert reset once that many writes have been seen.
  task automatic runLayer(input int idx, input int mode, input bit inject,
                          input int abortAt, output bit wasAborted);
    vec_t v;
    int   startCyc;
    int   n;
    int   budget;
    bit   injected;
    logic vld;
    v          = vec[idx];
    wasAborted = 1'b0;
    injected   = 1'b0;
    budget     = 2 * v.expTotal + 20;
    sb.delete();
    expAddr    = 16'd0;
    expBankB   = (v.port == BRAM_A);
    writesSeen = 0;
    doneCount  = 0;
    lastWrCyc  = -100;
    doneCyc    = -100;

    image_size  = v.image;
    kernel_size = v.kernel;
    padding     = v.pad;
    stride      = v.strd;
    port_input  = v.port;
    startCyc    = cyc;
    start       = 1'b1;
    applyStimulus(1'b0, 32'd0);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("err_cleared_on_start", 32'(err), 32'd0);
    checkOutput("ready_low_in_calc", 32'(pe_ready), 32'd0);

    // Scramble the configuration inputs to show they were latched.
    image_size  = 16'd7;
    kernel_size = 4'd2;
    padding     = ~v.pad;
    stride      = 2'd1;
    port_input  = (v.port == BRAM_A) ? BRAM_B : BRAM_A;

    n = 0;
    while (doneCount == 0 && n < budget) begin
      if (n == 1 && !v.expErr)
        checkOutput("ready_two_after_start", 32'(pe_ready), 32'd1);
      if (abortAt > 0 && writesSeen >= abortAt) begin
        rst = 1'b0;
        #1;
        checkResetValues("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        wasAborted = 1'b1;
        return;
      end
      vld = (mode == 0) || (n % 2 == 0);
      if (inject && !injected && writesSeen == 10) begin
        start    = 1'b1;
        injected = 1'b1;
      end
      applyStimulus(vld, $urandom);
      start = 1'b0;
      n++;
    end
    if (doneCount == 0)
      checkOutput("done_timeout", 32'd0, 32'd1);

    repeat (3) applyStimulus(1'b0, 32'd0);
    checkOutput("done_pulse_count", 32'(doneCount), 32'd1);
    checkOutput("write_count", 32'(writesSeen), 32'(v.expTotal));
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    checkOutput("err_flag", 32'(err), 32'(v.expErr));
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    if (v.expErr) begin
      checkOutput("err_done_latency", 32'(doneCyc - startCyc), 32'd2);
    end else begin
      checkOutput("out_size", 32'(out_size), 32'(v.expOut));
      checkOutput("done_after_last_write", 32'(doneCyc - lastWrCyc), 32'd1);
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec[0]  = '{16'd28,  4'd3, 1'b1, 2'd1, BRAM_A, 16'd28, 784, 1'b0};
    vec[1]  = '{16'd28,  4'd3, 1'b0, 2'd2, BRAM_B, 16'd13, 169, 1'b0};
    vec[2]  = '{16'd28,  4'd3, 1'b0, 2'd3, BRAM_A, 16'd0,  0,   1'b1};
    vec[3]  = '{16'd2,   4'd3, 1'b0, 2'd1, BRAM_B, 16'd0,  0,   1'b1};
    vec[4]  = '{16'd8,   4'd3, 1'b0, 2'd0, BRAM_A, 16'd6,  36,  1'b0};
    vec[5]  = '{16'd10,  4'd0, 1'b0, 2'd1, BRAM_A, 16'd0,  0,   1'b1};
    vec[6]  = '{16'd256, 4'd1, 1'b0, 2'd1, BRAM_B, 16'd0,  0,   1'b1};
    vec[7]  = '{16'd5,   4'd5, 1'b0, 2'd1, BRAM_B, 16'd1,  1,   1'b0};
    vec[8]  = '{16'd15,  4'd4, 1'b1, 2'd2, BRAM_A, 16'd7,  49,  1'b0};
    vec[9]  = '{16'd3,   4'd4, 1'b1, 2'd2, BRAM_B, 16'd1,  1,   1'b0};
    vec[10] = '{16'd2,   4'd3, 1'b1, 2'd1, BRAM_A, 16'd2,  4,   1'b0};

    rst         = 1'b0;
    start       = 1'b0;
    image_size  = 16'd0;
    kernel_size = 4'd0;
    padding     = 1'b0;
    stride      = 2'd0;
    port_input  = BRAM_A;
    pe_valid    = 1'b0;
    pe_data     = 32'd0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;
    @(negedge clk);
    monitorCycle();

    $display("[TB] pe_valid while idle");
    repeat (4) applyStimulus(1'b1, 32'hDEAD_BEEF);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_writes", 32'(writesSeen), 32'd0);

    $display("[TB] configuration table");
    for (int i = 0; i < NUM_VEC; i++) begin
      runLayer(i, 0, 1'b0, 0, aborted);
    end

    $display("[TB] pe_valid toggling");
    runLayer(0, 1, 1'b0, 0, aborted);

    $display("[TB] reset after 100 writes, then fresh layer");
    runLayer(0, 0, 1'b0, 100, aborted);
    checkOutput("abort_reached", 32'(aborted), 32'd1);
    runLayer(0, 0, 1'b0, 0, aborted);

    $display("[TB] start pulsed during WRITE");
    runLayer(1, 0, 1'b1, 0, aborted);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ofmap_writer.md
# ofmap_writer

Output-feature-map write-back controller for the BNN accelerator. It sits at the output end of the PE array and mirrors the input-feature-map fetch path: it accepts binarized PE results through a valid/ready handshake and writes them row-major into the ping-pong BRAM bank opposite the one being read. It signals layer completion so the sequencer can swap banks for the next layer.

## Interface
Parameters:
- ADDR_W, 16, BRAM word-address width.
- DATA_W, 32, output word width; one bit per output channel.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle layer start; sampled only in IDLE.
- image_size  in  16  input image width/height.
- kernel_size  in  4  kernel width/height.
- padding  in  1  1 = one pixel of zero padding on each side.
- stride  in  2  convolution stride.
- port_input  in  port_input_logic  bank being read (BRAM_A/BRAM_B); writes target the other bank.
- pe_valid  in  1  pe_data holds the final word of one output pixel.
- pe_data  in  DATA_W  binarized output pixel, all channels.
- pe_ready  out  1  writer accepts a word this cycle.
- wr_en_a  out  1  write strobe, bank A.
- wr_en_b  out  1  write strobe, bank B.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- out_size  out  16  computed output width/height; valid from WRITE until the next start.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at layer completion.
- err  out  1  sticky configuration error; cleared by the next accepted start.

## Operation
- States: IDLE, CALC, WRITE, DONE.
- IDLE -> CALC on start:
  - Latch all configuration inputs.
  - Latch the target bank as the inverse of port_input.
  - Clear err.
- CALC takes one cycle.
  - Computes eff = image_size + 2*padding.
  - Computes out_size = (eff - kernel_size)/stride + 1, where stride 0 is treated as 1 and stride 2 is a right shift.
  - Computes total = out_size*out_size, truncated to 16 bits.
- CALC error cases:
  - Conditions: stride==3, eff < kernel_size, kernel_size==0, or out_size > 255.
  - Action: set err, write nothing, go to DONE.
  - Otherwise go to WRITE.
- WRITE:
  - pe_ready = 1.
  - Each handshake (pe_valid & pe_ready) stores pe_data at the current address counter, which starts at 0 and increments by 1 per word.
  - After word number total is accepted, pe_ready drops in the same cycle and the FSM moves to DONE.
- DONE asserts done for one cycle, then returns to IDLE.
- Write-strobe rules:
  - Exactly one of wr_en_a/wr_en_b is asserted per accepted word.
  - Both are never high together.
- Addresses never wrap, because total ≤ 65025.

## Timing
- Reset values: pe_ready, wr_en_a, wr_en_b, done, busy and err = 0; wr_addr, wr_data and out_size = 0; FSM = IDLE.
- start high in cycle T (IDLE) gives CALC in T+1, and WRITE with pe_ready=1 from T+2.
- Write latency is 1 cycle. A handshake in cycle N drives wr_en_x, wr_addr and wr_data, registered, in cycle N+1.
- done:
  - Normal completion: asserted in the cycle after the last write strobe.
  - Error path: asserted 2 cycles after start.
- Back-to-back handshakes give one write per cycle. Gaps in pe_valid insert idle cycles with no strobes.
- start while busy is ignored. pe_valid outside WRITE is ignored; no write and no state change.
- An asynchronous rst assertion mid-layer returns all outputs to their reset values immediately. A partial layer is abandoned and not resumed.

## Configuration
- OFMAP_STALL_CNT_EN defined:
  - Adds output stall_cycles [31:0], counting WRITE cycles with pe_valid low.
  - Cleared on accepted start; held after DONE.
  - Reset value 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package bnn_pkg holds:
  - port_input_logic enum {BRAM_A, BRAM_B}.
  - ofmap_state_t enum.
  - MAX_OUT_SIZE = 255.
- Sub-module ofmap_addr_gen holds the output-size arithmetic, the total register and the address counter with terminal-count flag. The top level owns the FSM, handshake and write register.

## Test plan
- image_size=28, kernel=3, pad=1, stride=1, port_input=BRAM_A, pe_valid held high -> out_size=28; 784 wr_en_b strobes at addresses 0..783, wr_en_a never high; done one cycle after the write to address 783.
- image_size=28, kernel=3, pad=0, stride=2, port_input=BRAM_B -> out_size=13; 169 wr_en_a strobes at addresses 0..168; wr_data equals the accepted pe_data sequence.
- Same as test 1 with pe_valid toggled every other cycle -> exactly 784 writes, no address skipped or repeated, done 1 cycle after the final write.
- stride=3, or image_size=2 with kernel=3 and pad=0 -> err=1, no write strobes, done pulse 2 cycles after start; err cleared by the next valid start.
- rst driven low after 100 writes in test 1 -> outputs at reset values; a fresh start restarts at address 0 and completes 784 writes.
- start pulsed during WRITE -> ignored; configuration, address sequence and write count unchanged.
